pipe_skid_reg: RTL and testbench

Parametrised inter-stage pipeline register for the processor datapath, replacing fixed-field stage registers with one generic block. A payload is a control field (CTRL_W) and a data field (DATA_W). The payload moves between stages with a valid/ready handshake, and a two-entry skid buffer keeps `in_ready` fully registered. Flush and freeze keep their existing stage-register meaning: flush kills contents and presents a bubble; freeze holds everything.

---
 rtl/pipe_skid_reg_if.sv | 28 ++
 rtl/pipe_skid_reg.sv | 109 ++++++++++
 tb/tb_pipe_skid_reg.sv | 196 +++++++++++++++++++
 3 files changed

// File: rtl/pipe_skid_reg_if.sv
// Valid/ready payload handshake between two pipeline stages, plus the stage's flush/freeze controls.
// The producer side uses modport master; the stage register itself uses modport slave.
interface pipe_skid_reg_if #(
  parameter int unsigned DATA_W = 128,
  parameter int unsigned CTRL_W = 13
);
  logic              flush;
  logic              freeze;
  logic              in_valid;
  logic              in_ready;
  logic [CTRL_W-1:0] in_ctrl;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [CTRL_W-1:0] out_ctrl;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output flush, freeze, in_valid, in_ctrl, in_data, out_ready,
    input  in_ready, out_valid, out_ctrl, out_data, occupancy
  );

  modport slave (
    input  flush, freeze, in_valid, in_ctrl, in_data, out_ready,
    output in_ready, out_valid, out_ctrl, out_data, occupancy
  );
endinterface

// File: rtl/pipe_skid_reg.sv
// Generic inter-stage pipeline register with a two-entry skid buffer.
// in_ready depends only on registered state plus flush/freeze; flush kills entries, freeze holds all state.
module pipe_skid_reg #(
  parameter int unsigned DATA_W         = 128,
  parameter int unsigned CTRL_W         = 13,
  parameter bit          FLUSH_CLR_DATA = 1'b0
) (
  input  logic                clk,
  input  logic                rst,
  pipe_skid_reg_if.slave      bus
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_e;

  state_e            state_q, state_d;
  logic [CTRL_W-1:0] m_ctrl_q, m_ctrl_d;
  logic [DATA_W-1:0] m_data_q, m_data_d;
  logic [CTRL_W-1:0] s_ctrl_q, s_ctrl_d;
  logic [DATA_W-1:0] s_data_q, s_data_d;

  logic m_valid;
  logic s_valid;
  logic in_fire;
  logic out_fire;

  // Valid bits are decoded from the state so S valid without M is unrepresentable.
  assign m_valid = (state_q != EMPTY);
  assign s_valid = (state_q == TWO);

  assign bus.in_ready  = !s_valid && !bus.freeze && !bus.flush && !rst;
  assign bus.out_valid = m_valid && !bus.freeze && !bus.flush;
  assign bus.out_ctrl  = m_ctrl_q & {CTRL_W{m_valid}};
  assign bus.out_data  = m_data_q;
  assign bus.occupancy = 2'(m_valid) + 2'(s_valid);

  assign in_fire  = bus.in_valid && bus.in_ready;
  assign out_fire = bus.out_valid && bus.out_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= EMPTY;
      m_ctrl_q <= '0;
      m_data_q <= '0;
      s_ctrl_q <= '0;
      s_data_q <= '0;
    end else begin
      state_q  <= state_d;
      m_ctrl_q <= m_ctrl_d;
      m_data_q <= m_data_d;
      s_ctrl_q <= s_ctrl_d;
      s_data_q <= s_data_d;
    end
  end

  // Next-state and storage updates; fire signals are already gated by flush/freeze.
  always_comb begin
    state_d  = state_q;
    m_ctrl_d = m_ctrl_q;
    m_data_d = m_data_q;
    s_ctrl_d = s_ctrl_q;
    s_data_d = s_data_q;

    if (bus.flush) begin
      state_d  = EMPTY;
      m_ctrl_d = '0;
      s_ctrl_d = '0;
      if (FLUSH_CLR_DATA) begin
        m_data_d = '0;
        s_data_d = '0;
      end
    end else if (!bus.freeze) begin
      unique case (state_q)
        EMPTY: begin
          if (in_fire) begin
            m_ctrl_d = bus.in_ctrl;
            m_data_d = bus.in_data;
            state_d  = ONE;
          end
        end
        ONE: begin
          if (in_fire && out_fire) begin
            m_ctrl_d = bus.in_ctrl;
            m_data_d = bus.in_data;
          end else if (in_fire) begin
            s_ctrl_d = bus.in_ctrl;
            s_data_d = bus.in_data;
            state_d  = TWO;
          end else if (out_fire) begin
            m_ctrl_d = '0;
            state_d  = EMPTY;
          end
        end
        TWO: begin
          if (out_fire) begin
            m_ctrl_d = s_ctrl_q;
            m_data_d = s_data_q;
            state_d  = ONE;
          end
        end
        default: state_d = EMPTY;
      endcase
    end
  end

endmodule

// File: tb/tb_pipe_skid_reg.sv
// Bench for pipe_skid_reg: two instances (flush keeps / clears data) share stimulus and are
// compared against a queue-based model of the stage's ordering and flow-control rules.
module tb_pipe_skid_reg;
  localparam int unsigned DW = 128;
  localparam int unsigned CW = 13;

  typedef struct packed {
    logic [CW-1:0] c;
    logic [DW-1:0] d;
  } ent_t;

  logic clk;
  logic rst;

  pipe_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus0 ();
  pipe_skid_reg_if #(.DATA_W(DW), .CTRL_W(CW)) bus1 ();

  assign bus1.flush     = bus0.flush;
  assign bus1.freeze    = bus0.freeze;
  assign bus1.in_valid  = bus0.in_valid;
  assign bus1.in_ctrl   = bus0.in_ctrl;
  assign bus1.in_data   = bus0.in_data;
  assign bus1.out_ready = bus0.out_ready;

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_CLR_DATA(1'b0)) dut_keep (
    .clk (clk),
    .rst (rst),
    .bus (bus0)
  );

  pipe_skid_reg #(.DATA_W(DW), .CTRL_W(CW), .FLUSH_CLR_DATA(1'b1)) dut_clr (
    .clk (clk),
    .rst (rst),
    .bus (bus1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: FIFO of at most two entries; the head's data, once it leaves, lingers on out_data.
  ent_t          q[$];
  logic [DW-1:0] mdata_keep;
  logic [DW-1:0] mdata_clr;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic check_reset_values();
    chk("rst_in_ready0", DW'(bus0.in_ready), '0);
    chk("rst_out_valid0", DW'(bus0.out_valid), '0);
    chk("rst_out_ctrl0", DW'(bus0.out_ctrl), '0);
    chk("rst_out_data0", bus0.out_data, '0);
    chk("rst_occ0", DW'(bus0.occupancy), '0);
    chk("rst_in_ready1", DW'(bus1.in_ready), '0);
    chk("rst_out_valid1", DW'(bus1.out_valid), '0);
    chk("rst_out_data1", bus1.out_data, '0);
    chk("rst_occ1", DW'(bus1.occupancy), '0);
  endtask

  task automatic check_outputs();
    logic          ir, ov;
    logic [CW-1:0] ec;
    ir = !bus0.flush && !bus0.freeze && (q.size() < 2);
    ov = (q.size() > 0) && !bus0.freeze && !bus0.flush;
    ec = (q.size() > 0) ? q[0].c : '0;
    chk("in_ready0", DW'(bus0.in_ready), DW'(ir));
    chk("out_valid0", DW'(bus0.out_valid), DW'(ov));
    chk("out_ctrl0", DW'(bus0.out_ctrl), DW'(ec));
    chk("out_data0", bus0.out_data, mdata_keep);
    chk("occupancy0", DW'(bus0.occupancy), DW'(q.size()));
    chk("in_ready1", DW'(bus1.in_ready), DW'(ir));
    chk("out_valid1", DW'(bus1.out_valid), DW'(ov));
    chk("out_ctrl1", DW'(bus1.out_ctrl), DW'(ec));
    chk("out_data1", bus1.out_data, mdata_clr);
    chk("occupancy1", DW'(bus1.occupancy), DW'(q.size()));
  endtask

  task automatic model_edge();
    logic ir, ov;
    ent_t e;
    ir = !bus0.flush && !bus0.freeze && (q.size() < 2);
    ov = (q.size() > 0) && !bus0.freeze && !bus0.flush;
    if (bus0.flush) begin
      q.delete();
      mdata_clr = '0;
    end else begin
      if (ov && bus0.out_ready) void'(q.pop_front());
      if (bus0.in_valid && ir) begin
        e.c = bus0.in_ctrl;
        e.d = bus0.in_data;
        q.push_back(e);
      end
    end
    if (q.size() > 0) begin
      mdata_keep = q[0].d;
      mdata_clr  = q[0].d;
    end
  endtask

  // One cycle: drive at the falling edge, check before the rising edge, advance the model on it.
  task automatic step(input logic iv, input logic [CW-1:0] ic, input logic [DW-1:0] id,
                      input logic ordy, input logic fl, input logic fz);
    bus0.in_valid  = iv;
    bus0.in_ctrl   = ic;
    bus0.in_data   = id;
    bus0.out_ready = ordy;
    bus0.flush     = fl;
    bus0.freeze    = fz;
    #1;
    check_outputs();
    @(posedge clk);
    model_edge();
    @(negedge clk);
  endtask

  initial begin
    logic [DW-1:0] rd;
    rst            = 1'b1;
    bus0.in_valid  = 1'b0;
    bus0.in_ctrl   = '0;
    bus0.in_data   = '0;
    bus0.out_ready = 1'b0;
    bus0.flush     = 1'b0;
    bus0.freeze    = 1'b0;
    mdata_keep     = '0;
    mdata_clr      = '0;

    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_values();
    rst = 1'b0;

    // Streaming at full throughput.
    for (int i = 0; i < 4; i++) step(1'b1, CW'(i + 1), DW'(32'hA0 + i), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Backpressure: third payload must wait upstream, then drain in order.
    step(1'b1, CW'(1), DW'(32'hB0), 1'b0, 1'b0, 1'b0);
    step(1'b1, CW'(2), DW'(32'hB1), 1'b0, 1'b0, 1'b0);
    step(1'b1, CW'(3), DW'(32'hB2), 1'b0, 1'b0, 1'b0);
    step(1'b1, CW'(3), DW'(32'hB2), 1'b0, 1'b0, 1'b0);
    step(1'b1, CW'(3), DW'(32'hB2), 1'b1, 1'b0, 1'b0);
    step(1'b1, CW'(3), DW'(32'hB2), 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush in TWO: data kept on one instance, cleared on the other.
    step(1'b1, CW'(5), DW'(32'hD5), 1'b0, 1'b0, 1'b0);
    step(1'b1, CW'(6), DW'(32'hD6), 1'b0, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b0, 1'b1, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Freeze with one entry, upstream and downstream both eager.
    step(1'b1, CW'(7), DW'(32'hD7), 1'b0, 1'b0, 1'b0);
    repeat (3) step(1'b1, CW'(8), DW'(32'hD8), 1'b1, 1'b0, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Flush together with freeze drops the offered payload.
    step(1'b1, CW'(9), DW'(32'hD9), 1'b0, 1'b0, 1'b0);
    step(1'b1, CW'(10), DW'(32'hDA), 1'b1, 1'b1, 1'b1);
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Asynchronous reset between edges while holding two entries.
    step(1'b1, CW'(11), DW'(32'hDB), 1'b0, 1'b0, 1'b0);
    step(1'b1, CW'(12), DW'(32'hDC), 1'b0, 1'b0, 1'b0);
    bus0.in_valid = 1'b0;
    #2 rst = 1'b1;
    #1;
    check_reset_values();
    q.delete();
    mdata_keep = '0;
    mdata_clr  = '0;
    @(negedge clk);
    rst = 1'b0;
    step(1'b0, '0, '0, 1'b1, 1'b0, 1'b0);

    // Random traffic with occasional flush/freeze.
    for (int i = 0; i < 400; i++) begin
      rd = {$urandom(), $urandom(), $urandom(), $urandom()};
      step(($urandom_range(0, 9) < 7), CW'($urandom()), rd, ($urandom_range(0, 9) < 6),
           ($urandom_range(0, 19) == 0), ($urandom_range(0, 9) == 0));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
